// File: rtl/crypt_pkg.sv
// crypt_pkg: shared widths, FSM states and per-byte round functions for the cipher cores.
package crypt_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_BYTES = 4;
  localparam int NUM_WORDS = 4;
  localparam int WORD_W = BYTE_W * WORD_BYTES;
  typedef enum logic [2:0] {W0, W1, W2, W3, DRAIN, DONE} state_t;
  function automatic logic [2:0] rot_amt(input logic kh, input logic kl);
    return {1'b0, kh, kl} + 3'd1;
  endfunction
  function automatic logic [BYTE_W-1:0] round_mask(input logic kh, input logic kl);
    return {4{kh, kl}};
  endfunction
  function automatic logic [BYTE_W-1:0] rotr8(input logic [BYTE_W-1:0] x, input logic [2:0] r);
    logic [2*BYTE_W-1:0] t;
    t = {x, x} >> r;
    return t[BYTE_W-1:0];
  endfunction
  function automatic logic [BYTE_W-1:0] rotl8(input logic [BYTE_W-1:0] x, input logic [2:0] r);
    logic [2*BYTE_W-1:0] t;
    t = {x, x} << r;
    return t[2*BYTE_W-1:BYTE_W];
  endfunction
  function automatic logic [BYTE_W-1:0] inv_round_byte(input logic [BYTE_W-1:0] x, input logic kh, input logic kl);
    return rotr8(x, rot_amt(kh, kl)) ^ round_mask(kh, kl);
  endfunction
  // Exact inverse of inv_round_byte: mask first, then rotate the other way.
  function automatic logic [BYTE_W-1:0] enc_round_byte(input logic [BYTE_W-1:0] x, input logic kh, input logic kl);
    return rotl8(x ^ round_mask(kh, kl), rot_amt(kh, kl));
  endfunction
endpackage

// File: rtl/dec_stage.sv
// dec_stage: one registered inverse round over a 4-byte word, carrying its valid bit.
module dec_stage
  import crypt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              kh,
  input  logic              kl,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_v,
  output logic [WORD_W-1:0] out_word,
  output logic              out_v
);
  logic [WORD_W-1:0] nxt;
  always_comb begin
    nxt = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      nxt[BYTE_W*i +: BYTE_W] = inv_round_byte(in_word[BYTE_W*i +: BYTE_W], kh, kl);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_word <= '0;
      out_v <= 1'b0;
    end else if (Enable) begin
      out_word <= nxt;
      out_v <= in_v;
    end
  end
endmodule

// File: rtl/pipelined_processor_dec.sv
// pipelined_processor_dec: three-stage inverse-round pipeline decrypting one 16-byte block.
module pipelined_processor_dec
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       Enable,
  input  logic [7:0] a0, a1, a2, a3,
  input  logic [7:0] b0, b1, b2, b3,
  input  logic [7:0] c0, c1, c2, c3,
  input  logic [7:0] d0, d1, d2, d3,
  input  logic [9:4] key,
  output logic       finished,
  output logic [7:0] w0, w1, w2, w3,
  output logic [7:0] w4, w5, w6, w7,
  output logic [7:0] w8, w9, w10, w11,
  output logic [7:0] w12, w13, w14, w15
);
  state_t state;
  logic en, inj_v, v1, v2, v3;
  logic [WORD_W-1:0] inj, s1, s2, s3;
  logic [1:0] idx;
  logic [WORD_W-1:0] slot [NUM_WORDS];
  logic [WORD_W-1:0] res [NUM_WORDS];
  // DONE freezes the pipeline as if Enable were low.
  assign en = Enable && state != DONE;
  assign inj_v = state inside {W0, W1, W2, W3};
  always_comb begin
    inj = state == W0 ? {a3, a2, a1, a0} :
          state == W1 ? {b3, b2, b1, b0} :
          state == W2 ? {c3, c2, c1, c0} :
          state == W3 ? {d3, d2, d1, d0} : '0;
  end
  dec_stage u_d1 (.clk(clk), .reset(reset), .Enable(en), .kh(key[5]), .kl(key[4]),
                  .in_word(inj), .in_v(inj_v), .out_word(s1), .out_v(v1));
  dec_stage u_d2 (.clk(clk), .reset(reset), .Enable(en), .kh(key[7]), .kl(key[6]),
                  .in_word(s1), .in_v(v1), .out_word(s2), .out_v(v2));
  dec_stage u_d3 (.clk(clk), .reset(reset), .Enable(en), .kh(key[9]), .kl(key[8]),
                  .in_word(s2), .in_v(v2), .out_word(s3), .out_v(v3));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= W0;
      idx <= '0;
      finished <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        slot[i] <= '0;
        res[i] <= '0;
      end
    end else if (en) begin
      state <= state == W0 ? W1 :
               state == W1 ? W2 :
               state == W2 ? W3 :
               state == W3 ? DRAIN :
               (v3 && idx == 2'd3) ? DONE : state;
      if (v3) begin
        slot[idx] <= s3;
        idx <= idx + 2'd1;
        // The last word goes straight from D3 into the published result.
        if (idx == 2'd3) begin
          finished <= 1'b1;
          for (int i = 0; i < NUM_WORDS - 1; i++) res[i] <= slot[i];
          res[NUM_WORDS-1] <= s3;
        end
      end
    end
  end
  assign w0 = res[0][7:0];
  assign w1 = res[0][15:8];
  assign w2 = res[0][23:16];
  assign w3 = res[0][31:24];
  assign w4 = res[1][7:0];
  assign w5 = res[1][15:8];
  assign w6 = res[1][23:16];
  assign w7 = res[1][31:24];
  assign w8 = res[2][7:0];
  assign w9 = res[2][15:8];
  assign w10 = res[2][23:16];
  assign w11 = res[2][31:24];
  assign w12 = res[3][7:0];
  assign w13 = res[3][15:8];
  assign w14 = res[3][23:16];
  assign w15 = res[3][31:24];
endmodule
